// File: rtl/tdc_uart_framer.sv
// tdc_uart_framer: buffers 64-bit TDC snapshots in a small FIFO and sends
// each one as an 11-byte UART 8N1 frame: A5, seq, D0..D7, CHK.
//
// Ports:
//   sysclk_200mhz_passthrough  clock
//   rst                        synchronous active-high reset
//   sample_data[63:0]          snapshot, byte k = bits [8k+7:8k]
//   sample_valid               1-cycle strobe qualifying sample_data
//   uart_tx                    serial line, idles high
//   busy                       frame on the wire or FIFO non-empty
//   frame_sent                 pulse at the end of the last stop bit
//   drop_count[7:0]            samples lost on a full FIFO, saturating
module tdc_uart_framer #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        sysclk_200mhz_passthrough,
  input  logic        rst,
  input  logic [63:0] sample_data,
  input  logic        sample_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_sent,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [63:0]   hold;
  logic [7:0]    chk;
  logic [7:0]    seq;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  logic          fifo_empty;
  logic          fifo_full;
  logic          bit_end;
  logic          frame_done;
  logic          pop;
  logic          push;
  logic          drop;
  logic [63:0]   head;
  logic [7:0]    next_seq;
  logic [7:0]    head_chk;
  logic [7:0]    cur_byte;
  logic [2:0]    dsel;
  logic          tx_next;
  logic          done_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL);
  assign bit_end    = (clk_cnt == LAST_CLK);
  assign frame_done = (state == STOP) && bit_end
                    && (byte_idx == 4'd10);

  // A pop happens from IDLE, or at the end of a frame so the
  // next frame follows without an idle bit.
  assign pop  = !fifo_empty
              && ((state == IDLE) || frame_done);
  assign push = sample_valid && (!fifo_full || pop);
  assign drop = sample_valid && fifo_full && !pop;
  assign head = mem[rd_ptr];

  // A back-to-back pop coincides with the seq increment, so the
  // checksum must already use the incremented value.
  assign next_seq = frame_done ? seq + 8'd1 : seq;

  always_comb begin
    head_chk = next_seq;
    for (int k = 0; k < 8; k++) begin
      head_chk = head_chk ^ head[8*k +: 8];
    end
  end

  assign dsel = 3'(byte_idx - 4'd2);

  always_comb begin
    cur_byte = hold[{dsel, 3'b000} +: 8];
    case (byte_idx)
      4'd0:    cur_byte = 8'hA5;
      4'd1:    cur_byte = seq;
      4'd10:   cur_byte = chk;
      default: cur_byte = hold[{dsel, 3'b000} +: 8];
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_idx];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk_200mhz_passthrough) begin
    if (push) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  always_ff @(posedge sysclk_200mhz_passthrough) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge sysclk_200mhz_passthrough) begin
    if (rst) begin
      drop_count <= 8'd0;
    end else if (drop && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge sysclk_200mhz_passthrough) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      hold     <= 64'd0;
      chk      <= 8'd0;
      seq      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold     <= head;
            chk      <= head_chk;
            byte_idx <= 4'd0;
            clk_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx != 4'd10) begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
            end else begin
              seq <= seq + 8'd1;
              if (pop) begin
                hold     <= head;
                chk      <= head_chk;
                byte_idx <= 4'd0;
                state    <= START;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Outputs are registered one cycle behind the FSM; frame_sent
  // takes one more stage so it lands where the last stop bit ends
  // on uart_tx.
  always_ff @(posedge sysclk_200mhz_passthrough) begin
    if (rst) begin
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      done_q     <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      uart_tx    <= tx_next;
      busy       <= (state != IDLE) || !fifo_empty;
      done_q     <= frame_done;
      frame_sent <= done_q;
    end
  end

endmodule

// File: tb/tb_tdc_uart_framer.sv
// tb_tdc_uart_framer: directed bench for tdc_uart_framer.
// A line monitor decodes uart_tx bytes; scenario tasks check frames.
module tb_tdc_uart_framer;

  localparam int CPB   = 2;
  localparam int FLEN  = 110 * CPB;
  localparam int BUDGET = 130 * CPB + 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sample_data;
  logic        sample_valid;
  logic        uart_tx;
  logic        busy;
  logic        frame_sent;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs_count = 0;
  int fs_cyc   = 0;
  int stop_err = 0;

  logic [7:0] rx_q [$];
  int         rx_cyc_q [$];
  logic [7:0] fr [11];
  int         fr_sc;
  int         fr_last;
  logic [7:0] ex [11];

  int         msc;
  logic [7:0] mb;

  tdc_uart_framer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .sysclk_200mhz_passthrough(clk),
    .rst(rst),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .uart_tx(uart_tx),
    .busy(busy),
    .frame_sent(frame_sent),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_sent === 1'b1) begin
      fs_count <= fs_count + 1;
      fs_cyc   <= cyc;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        msc = cyc;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mb[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) stop_err++;
        rx_q.push_back(mb);
        rx_cyc_q.push_back(msc);
      end
    end
  end

  task automatic strobe(input logic [63:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic get_frame(output bit ok);
    int t;
    t = 0;
    while (rx_q.size() < 11 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    ok = (rx_q.size() >= 11);
    if (ok) begin
      for (int i = 0; i < 11; i++) begin
        fr[i] = rx_q.pop_front();
        if (i == 0)  fr_sc   = rx_cyc_q.pop_front();
        else if (i == 10) fr_last = rx_cyc_q.pop_front();
        else void'(rx_cyc_q.pop_front());
      end
    end
  endtask

  task automatic flush;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB + 4) @(negedge clk);
    rx_q.delete();
    rx_cyc_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_data = 64'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx got %b want 1", uart_tx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (frame_sent !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fs got %b want 0", frame_sent);
    end
    n_checks++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop got %0d want 0", drop_count);
    end
  endtask

  task automatic test_single;
    bit ok;
    int sv;
    ex = '{8'hA5, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89,
           8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
    strobe(64'h0123456789ABCDEF);
    sv = cyc;
    get_frame(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_rx got %0d bytes want 11",
               rx_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (fr[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL single_byte%0d got %h want %h",
                   i, fr[i], ex[i]);
        end
      end
      n_checks++;
      if (fr_sc - sv !== 2) begin
        n_fail++;
        $display("FAIL single_latency got %0d want 2",
                 fr_sc - sv);
      end
      n_checks++;
      if (fr_last - fr_sc !== 100 * CPB) begin
        n_fail++;
        $display("FAIL single_bytegap got %0d want %0d",
                 fr_last - fr_sc, 100 * CPB);
      end
      repeat (4 * CPB) @(negedge clk);
      n_checks++;
      if (fs_cyc - fr_sc !== FLEN) begin
        n_fail++;
        $display("FAIL single_fs got %0d want %0d",
                 fs_cyc - fr_sc, FLEN);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_busy got %b want 0", busy);
      end
      n_checks++;
      if (stop_err !== 0) begin
        n_fail++;
        $display("FAIL single_stop got %0d want 0", stop_err);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int prev;
    logic [7:0] s;
    flush();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 64'(i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL burst_drop got %0d want 1", drop_count);
    end
    prev = 0;
    for (int f = 0; f < 5; f++) begin
      get_frame(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL burst_rx frame %0d timed out", f);
      end else begin
        s = 8'(f);
        ex = '{8'hA5, s, s + 8'd1, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, s ^ (s + 8'd1)};
        for (int i = 0; i < 11; i++) begin
          n_checks++;
          if (fr[i] !== ex[i]) begin
            n_fail++;
            $display("FAIL burst_f%0d_b%0d got %h want %h",
                     f, i, fr[i], ex[i]);
          end
        end
        if (f > 0) begin
          n_checks++;
          if (fr_sc - prev !== FLEN) begin
            n_fail++;
            $display("FAIL burst_gap%0d got %0d want %0d",
                     f, fr_sc - prev, FLEN);
          end
        end
        prev = fr_sc;
      end
    end
    repeat (40 * CPB) @(negedge clk);
    n_checks++;
    if (rx_q.size() !== 0) begin
      n_fail++;
      $display("FAIL burst_extra got %0d bytes want 0",
               rx_q.size());
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_saturation;
    flush();
    for (int i = 0; i < 105; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 64'(i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks++;
    if (drop_count !== 8'd100) begin
      n_fail++;
      $display("FAIL sat_partial got %0d want 100", drop_count);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks++;
    if (drop_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_full got %0d want 255", drop_count);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_checks++;
    if (drop_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold got %0d want 255", drop_count);
    end
    flush();
  endtask

  task automatic test_seq_wrap;
    bit ok;
    int seq_bad;
    logic [63:0] d;
    seq_bad = 0;
    for (int f = 0; f < 257; f++) begin
      if (f == 255) d = 64'h11;
      else if (f == 256) d = 64'hA5;
      else d = 64'(f);
      strobe(d);
      get_frame(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_rx frame %0d timed out", f);
        break;
      end
      if (fr[1] !== 8'(f)) seq_bad++;
      if (f == 255) begin
        n_checks++;
        if (fr[1] !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap_seq255 got %h want ff", fr[1]);
        end
        n_checks++;
        if (fr[10] !== 8'hEE) begin
          n_fail++;
          $display("FAIL wrap_chk255 got %h want ee", fr[10]);
        end
      end
      if (f == 256) begin
        n_checks++;
        if (fr[1] !== 8'h00) begin
          n_fail++;
          $display("FAIL wrap_seq256 got %h want 00", fr[1]);
        end
        n_checks++;
        if (fr[10] !== 8'hA5) begin
          n_fail++;
          $display("FAIL wrap_chk256 got %h want a5", fr[10]);
        end
      end
    end
    n_checks++;
    if (seq_bad !== 0) begin
      n_fail++;
      $display("FAIL wrap_seq_all got %0d bad want 0", seq_bad);
    end
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int t;
    strobe(64'hFFEEDDCCBBAA9988);
    t = 0;
    while (rx_q.size() < 3 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rx_q.size() < 3) begin
      n_fail++;
      $display("FAIL mid_rx got %0d bytes want 3", rx_q.size());
    end
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_pre got %b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_tx got %b want 1", uart_tx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got %b want 0", busy);
    end
    rst = 1'b0;
    repeat (12 * CPB + 4) @(negedge clk);
    rx_q.delete();
    rx_cyc_q.delete();
    ex = '{8'hA5, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89,
           8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
    strobe(64'h0123456789ABCDEF);
    get_frame(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_after_rx timed out");
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (fr[i] !== ex[i]) begin
          n_fail++;
          $display("FAIL mid_after_b%0d got %h want %h",
                   i, fr[i], ex[i]);
        end
      end
    end
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic test_idle_line;
    int bad;
    int fs0;
    flush();
    bad = 0;
    fs0 = fs_count;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_line got %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (fs_count !== fs0) begin
      n_fail++;
      $display("FAIL idle_fs got %0d pulses want 0",
               fs_count - fs0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_seq_wrap();
    test_reset_mid_frame();
    test_idle_line();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
